// File: rtl/rom_scan_streamer_pkg.sv
// Shared types for the ROM scan front end and the thresholding stages:
// scan FSM encoding and the per-pixel raster sideband.
package rom_scan_streamer_pkg;

    localparam int unsigned COORD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } sideband_t;

    localparam int unsigned SIDEBAND_W = $bits(sideband_t);

    function automatic sideband_t make_sideband(
        input logic [COORD_W-1:0] col,
        input logic [COORD_W-1:0] row,
        input logic [COORD_W-1:0] col_last,
        input logic [COORD_W-1:0] row_last
    );
        sideband_t sb;
        sb.sof = (col == '0) && (row == '0);
        sb.eol = (col == col_last);
        sb.eof = sb.eol && (row == row_last);
        return sb;
    endfunction

endpackage

// File: rtl/rom_scan_streamer_fifo.sv
// Synchronous FIFO with occupancy count; the writer is expected to respect
// credit so a push never lands on a full FIFO.
module stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             full;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    no_push_when_full: assert property (
        @(posedge clock) disable iff (!reset_n) !(push && full)
    );

endmodule

// File: rtl/rom_scan_streamer.sv
// Raster-scan address generator for the input ROM reader; realigns the
// fixed-latency ROM data with sideband flags into a credit-throttled stream.
module rom_scan_streamer
    import rom_scan_streamer_pkg::*;
#(
    parameter int unsigned WIDTH        = 128,
    parameter int unsigned HEIGHT       = 128,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iStart,
    output logic [7:0] oCol,
    output logic [7:0] oRow,
    input  logic [7:0] iRomData,
    output logic [7:0] oPixel,
    output logic       oValid,
    input  logic       iReady,
    output logic       oSof,
    output logic       oEol,
    output logic       oEof,
    output logic       oBusy,
    output logic       oDone
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned FW = COORD_W + SIDEBAND_W;
    localparam logic [7:0]  COL_LAST = 8'(WIDTH - 1);
    localparam logic [7:0]  ROW_LAST = 8'(HEIGHT - 1);

    scan_state_t             state;
    scan_state_t             state_next;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           inflight;
    logic [READ_LATENCY-1:0] pipe_valid;
    sideband_t               pipe_sb [READ_LATENCY];
    logic                    credit_ok;
    logic                    issue;
    logic                    last_coord;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic [FW-1:0]           fifo_head;
    sideband_t               head_sb;

    assign last_coord = (oCol == COL_LAST) && (oRow == ROW_LAST);
    assign credit_ok  = (SW'(fifo_count) + SW'(inflight) + SW'(1)) <= SW'(FIFO_DEPTH);
    assign issue      = (state == ST_SCAN) && credit_ok;
    assign push       = pipe_valid[READ_LATENCY-1];
    assign pop        = !fifo_empty && iReady;

    always_comb begin
        state_next = state;
        oDone      = 1'b0;
        case (state)
            ST_IDLE:  if (iStart) state_next = ST_SCAN;
            ST_SCAN:  if (issue && last_coord) state_next = ST_DRAIN;
            // Leave DRAIN on the edge that pops the final entry so oDone
            // follows the last accept by exactly one cycle.
            ST_DRAIN: if (inflight == '0 &&
                          (fifo_empty || (fifo_count == CW'(1) && pop)))
                          state_next = ST_DONE;
            ST_DONE: begin
                oDone      = 1'b1;
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            oCol       <= '0;
            oRow       <= '0;
            oBusy      <= 1'b0;
            inflight   <= '0;
            pipe_valid <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++)
                pipe_sb[i] <= '0;
        end else begin
            state <= state_next;

            if (state == ST_IDLE && iStart) begin
                oCol <= '0;
                oRow <= '0;
            end else if (issue && !last_coord) begin
                if (oCol == COL_LAST) begin
                    oCol <= '0;
                    oRow <= oRow + 8'd1;
                end else begin
                    oCol <= oCol + 8'd1;
                end
            end

            if (state == ST_IDLE && iStart)
                oBusy <= 1'b1;
            else if (state == ST_DONE)
                oBusy <= 1'b0;

            case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            pipe_valid[0] <= issue;
            pipe_sb[0]    <= make_sideband(oCol, oRow, COL_LAST, ROW_LAST);
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_sb[i]    <= pipe_sb[i-1];
            end
        end
    end

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({pipe_sb[READ_LATENCY-1], iRomData}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_sb = sideband_t'(fifo_head[FW-1:COORD_W]);
    assign oValid  = !fifo_empty;
    assign oPixel  = oValid ? fifo_head[COORD_W-1:0] : '0;
    assign oSof    = oValid && head_sb.sof;
    assign oEol    = oValid && head_sb.eol;
    assign oEof    = oValid && head_sb.eof;

endmodule

// File: tb/tb_rom_scan_streamer.sv
// Scoreboard bench for rom_scan_streamer: 4x3, 128x128 and 1x1 instances,
// each fed by a two-stage ROM model.
module tb_rom_scan_streamer;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic rand_en = 1'b0;

    logic [7:0] col [3];
    logic [7:0] row [3];
    logic [7:0] romd [3];
    logic [7:0] s1 [3];
    logic [7:0] pix [3];
    logic       vld [3];
    logic       sof [3];
    logic       eol [3];
    logic       eof [3];
    logic       busy [3];
    logic       done [3];

    int total = 0, bad = 0;
    int beats = 0, sof_cnt = 0, eof_cnt = 0, done_cnt = 0;
    int cyc = 0, first_acc = 0, last_acc = 0;
    logic [10:0] exp_q [$];
    logic [10:0] e;
    logic [2:0]  rv;

    function automatic logic [7:0] rom_val(input int a);
        return 8'(a) ^ 8'(a >> 8);
    endfunction

    always @(posedge clock) begin
        s1[0] <= rom_val(int'(row[0]) * 4 + int'(col[0]));
        s1[1] <= rom_val(int'(row[1]) * 128 + int'(col[1]));
        s1[2] <= rom_val(int'(row[2]) + int'(col[2]));
        for (int k = 0; k < 3; k++)
            romd[k] <= s1[k];
    end

    rom_scan_streamer #(.WIDTH(4), .HEIGHT(3), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_small (
        .clock(clock), .reset_n(reset_n), .iStart(st0), .oCol(col[0]), .oRow(row[0]),
        .iRomData(romd[0]), .oPixel(pix[0]), .oValid(vld[0]), .iReady(rdy0),
        .oSof(sof[0]), .oEol(eol[0]), .oEof(eof[0]), .oBusy(busy[0]), .oDone(done[0]));

    rom_scan_streamer #(.WIDTH(128), .HEIGHT(128), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_big (
        .clock(clock), .reset_n(reset_n), .iStart(st1), .oCol(col[1]), .oRow(row[1]),
        .iRomData(romd[1]), .oPixel(pix[1]), .oValid(vld[1]), .iReady(rdy1),
        .oSof(sof[1]), .oEol(eol[1]), .oEof(eof[1]), .oBusy(busy[1]), .oDone(done[1]));

    rom_scan_streamer #(.WIDTH(1), .HEIGHT(1), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_one (
        .clock(clock), .reset_n(reset_n), .iStart(st2), .oCol(col[2]), .oRow(row[2]),
        .iRomData(romd[2]), .oPixel(pix[2]), .oValid(vld[2]), .iReady(rdy2),
        .oSof(sof[2]), .oEol(eol[2]), .oEof(eof[2]), .oBusy(busy[2]), .oDone(done[2]));

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    initial forever begin
        @(posedge clock);
        #1;
        rdy1 = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the expected beat whenever any instance hands one over.
    always @(negedge clock) begin
        rv = {rdy2, rdy1, rdy0};
        for (int k = 0; k < 3; k++) begin
            if (vld[k] && rv[k]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", longint'({busy[k], sof[k], eol[k], eof[k], pix[k]}),
                        longint'({1'b1, e}));
                end
                beats++;
                last_acc = cyc;
                if (sof[k]) begin
                    sof_cnt++;
                    first_acc = cyc;
                end
                if (eof[k]) eof_cnt++;
            end
            if (done[k]) begin
                done_cnt++;
                chk("done_after_last_accept", cyc - last_acc, 1);
            end
        end
    end

    task automatic push_frame(input int w, input int h);
        int c, r;
        for (int i = 0; i < w * h; i++) begin
            c = i % w;
            r = i / w;
            exp_q.push_back({(c == 0 && r == 0), (c == w - 1), (c == w - 1 && r == h - 1),
                             rom_val(i)});
        end
    endtask

    task automatic set_start(input int k, input logic v);
        case (k)
            0:       st0 = v;
            1:       st1 = v;
            default: st2 = v;
        endcase
    endtask

    task automatic pulse(input int k);
        @(posedge clock); #1;
        set_start(k, 1'b1);
        @(posedge clock); #1;
        set_start(k, 1'b0);
    endtask

    task automatic start_frame(input int k);
        pulse(k);
        chk("start_col", col[k], 0);
        chk("start_row", row[k], 0);
        chk("start_busy", busy[k], 1);
    endtask

    task automatic reset_counts();
        beats = 0; sof_cnt = 0; eof_cnt = 0;
    endtask

    task automatic wait_done(input int k, input int limit);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done[k] && n < limit);
        chk("done_seen", done[k], 1);
        chk("busy_in_done", busy[k], 1);
        #1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", vld[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_done", done[k], 0);
            chk("rst_coord", longint'({row[k], col[k]}), 0);
            chk("rst_out", longint'({sof[k], eol[k], eof[k], pix[k]}), 0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // 4x3 frame, always ready
        reset_counts();
        push_frame(4, 3);
        start_frame(0);
        n = 1;
        @(negedge clock);
        while (!vld[0] && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("first_valid_cycle", n, 4);
        wait_done(0, 100);
        chk("t1_beats", beats, 12);
        chk("t1_sof", sof_cnt, 1);
        chk("t1_eof", eof_cnt, 1);
        chk("t1_contiguous", last_acc - first_acc, 11);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_queue", exp_q.size(), 0);
        @(posedge clock); #1;
        chk("busy_clear", busy[0], 0);

        // backpressure: credit must stop issue at (0,1) with four held
        rdy0 = 1'b0;
        reset_counts();
        push_frame(4, 3);
        start_frame(0);
        repeat (20) @(posedge clock);
        #1;
        chk("hold_col", col[0], 0);
        chk("hold_row", row[0], 1);
        chk("hold_valid", vld[0], 1);
        chk("hold_head", longint'({sof[0], pix[0]}), longint'({1'b1, 8'd0}));
        chk("hold_beats", beats, 0);
        chk("hold_busy", busy[0], 1);
        rdy0 = 1'b1;
        wait_done(0, 100);
        chk("t2_beats", beats, 12);
        chk("t2_done_cnt", done_cnt, 2);
        chk("t2_queue", exp_q.size(), 0);

        // iStart during SCAN and DRAIN is ignored; restart right after oDone
        reset_counts();
        push_frame(4, 3);
        start_frame(0);
        pulse(0);
        repeat (9) @(posedge clock);
        pulse(0);
        chk("drain_coord", longint'({row[0], col[0]}), longint'({8'd2, 8'd3}));
        wait_done(0, 100);
        chk("t4_beats", beats, 12);
        chk("t4_done_cnt", done_cnt, 3);
        reset_counts();
        push_frame(4, 3);
        start_frame(0);
        wait_done(0, 100);
        chk("t4b_beats", beats, 12);
        chk("t4b_done_cnt", done_cnt, 4);
        chk("t4b_queue", exp_q.size(), 0);

        // 1x1 frame
        reset_counts();
        push_frame(1, 1);
        start_frame(2);
        wait_done(2, 50);
        chk("t6_beats", beats, 1);
        chk("t6_sof_eof", sof_cnt + eof_cnt, 2);
        chk("t6_done_cnt", done_cnt, 5);
        chk("t6_queue", exp_q.size(), 0);

        // reset mid-frame after pixel 37
        reset_counts();
        push_frame(128, 128);
        start_frame(1);
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (beats < 38 && n < 200);
        chk("t5_reached_37", beats, 38);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_async_valid", vld[1], 0);
        chk("t5_async_out", longint'({busy[1], done[1], sof[1], eol[1], eof[1], pix[1]}), 0);
        chk("t5_async_coord", longint'({row[1], col[1]}), 0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        #1;
        chk("t5_no_done", done_cnt, 5);
        chk("t5_idle_busy", busy[1], 0);
        chk("t5_idle_valid", vld[1], 0);

        // full 128x128 frame with random backpressure
        reset_counts();
        push_frame(128, 128);
        rand_en = 1'b1;
        start_frame(1);
        wait_done(1, 60000);
        rand_en = 1'b0;
        chk("t3_beats", beats, 16384);
        chk("t3_sof", sof_cnt, 1);
        chk("t3_eof", eof_cnt, 1);
        chk("t3_done_cnt", done_cnt, 6);
        chk("t3_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
